int_ctrl: RTL and testbench



---
 rtl/int_ctrl_pkg.sv | 26 ++
 rtl/int_ctrl_prio_enc.sv | 23 ++
 rtl/int_ctrl.sv | 129 ++++++++++++
 tb/tb_int_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared state encoding, defaults and vector helper for int_ctrl
package int_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    SVC  = ST_SVC
  } state_t;

  localparam int         NIRQ_DEF    = 8;
  localparam logic [9:0] VBASE_DEF   = 10'h380;
  localparam int         VSTRIDE_DEF = 8;

  // Vector address of line idx, truncated to the 10-bit PC range.
  function automatic logic [9:0] vec_addr(input int idx, input logic [9:0] vbase,
                                          input int vstride);
    int sum;
    sum = int'(vbase) + idx * vstride;
    return sum[9:0];
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// rtl/int_ctrl_prio_enc.sv - lowest-index priority encoder
module prio_enc #(
  parameter int NBITS = 8,
  parameter int IW    = (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic [NBITS-1:0] req,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-capturing, maskable, lowest-index-first interrupt controller
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int         NIRQ    = NIRQ_DEF,
  parameter logic [9:0] VBASE   = VBASE_DEF,
  parameter int         VSTRIDE = VSTRIDE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_d,
  input  logic            int_ack,
  input  logic            eoi,
  output logic            int_req,
  output logic [9:0]      vector,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] in_service
);

  localparam int IW = $clog2(NIRQ);

  // Reject configurations whose last vector would wrap past the 10-bit PC.
  if (NIRQ < 2 || NIRQ > 16) begin : g_bad_nirq
    $error("int_ctrl: NIRQ must be 2..16");
  end
  if (int'(VBASE) + (NIRQ - 1) * VSTRIDE > 1023) begin : g_bad_vec
    $error("int_ctrl: vector table exceeds 10-bit address space");
  end

  state_t          state_q, state_d;
  logic [NIRQ-1:0] irq_d_q;
  logic            armed_q;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] en_mask_q, en_mask_d;
  logic [NIRQ-1:0] in_service_q, in_service_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            int_req_q, int_req_d;
  logic [9:0]      vector_q, vector_d;

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] clr;
  logic [NIRQ-1:0] cand;
  logic            cand_valid;
  logic [IW-1:0]   cand_idx;

  assign cand = pending_q & en_mask_q;

  prio_enc #(.NBITS(NIRQ), .IW(IW)) u_prio_enc (
    .req  (cand),
    .valid(cand_valid),
    .idx  (cand_idx)
  );

  // Next-state, pending update and registered outputs of the request/ack/eoi handshake.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    en_mask_d    = mask_we ? mask_d : en_mask_q;
    clr          = '0;
    // irq_d holds reset zeros until the first post-reset clock has loaded it,
    // so edges are suppressed then; a line held high through reset is not an edge.
    irq_edge     = irq & ~irq_d_q & {NIRQ{armed_q}};

    unique case (state_q)
      IDLE: begin
        if (cand_valid) begin
          idx_d     = cand_idx;
          vector_d  = vec_addr(int'(cand_idx), VBASE, VSTRIDE);
          int_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          clr          = NIRQ'(1) << idx_q;
          in_service_d = NIRQ'(1) << idx_q;
          int_req_d    = 1'b0;
          state_d      = SVC;
        end
      end
      SVC: begin
        if (eoi) begin
          in_service_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear on the same line.
    pending_d = (pending_q & ~clr) | irq_edge;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_d_q      <= '0;
      armed_q      <= 1'b0;
      pending_q    <= '0;
      en_mask_q    <= '0;
      in_service_q <= '0;
      idx_q        <= '0;
      int_req_q    <= 1'b0;
      vector_q     <= VBASE;
    end else begin
      state_q      <= state_d;
      irq_d_q      <= irq;
      armed_q      <= 1'b1;
      pending_q    <= pending_d;
      en_mask_q    <= en_mask_d;
      in_service_q <= in_service_d;
      idx_q        <= idx_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
    end
  end

  assign int_req    = int_req_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_d;
  logic       int_ack;
  logic       eoi;
  logic       int_req;
  logic [9:0] vector;
  logic [7:0] pending;
  logic [7:0] in_service;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.NIRQ(8), .VBASE(10'h380), .VSTRIDE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_d    (mask_d),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .int_req   (int_req),
    .vector    (vector),
    .pending   (pending),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic [9:0] v,
                         input logic [7:0] p, input logic [7:0] s);
    chk({tag, ".int_req"}, 32'(int_req), 32'(r));
    chk({tag, ".vector"}, 32'(vector), 32'(v));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
    chk({tag, ".in_service"}, 32'(in_service), 32'(s));
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_d  = m;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_d = '0; int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 10'h380, 8'h00, 8'h00);
    reset = 1'b0;
    tick();

    // Single line 3
    write_mask(8'hFF);
    irq = 8'h08; tick();
    chk_out("l3_edge", 1'b0, 10'h380, 8'h08, 8'h00);
    irq = 8'h00; tick();
    chk_out("l3_req", 1'b1, 10'h398, 8'h08, 8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk_out("l3_ack", 1'b0, 10'h398, 8'h00, 8'h08);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk_out("l3_eoi", 1'b0, 10'h398, 8'h00, 8'h00);

    // Lines 5 and 2 together: 2 first, then 5
    irq = 8'h24; tick(); irq = 8'h00;
    chk("both_pend", 32'(pending), 32'h24);
    tick();
    chk_out("l2_req", 1'b1, 10'h390, 8'h24, 8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk_out("l2_ack", 1'b0, 10'h390, 8'h20, 8'h04);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk_out("l2_eoi", 1'b0, 10'h390, 8'h20, 8'h00);
    tick();
    chk_out("l5_req", 1'b1, 10'h3A8, 8'h20, 8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk_out("l5_done", 1'b0, 10'h3A8, 8'h00, 8'h00);

    // Masked line 1, later enabled
    write_mask(8'h00);
    irq = 8'h02; tick(); irq = 8'h00;
    chk("m1_pend", 32'(pending), 32'h02);
    tick(); tick();
    chk("m1_noreq", 32'(int_req), 32'h0);
    write_mask(8'h02);
    chk("m1_wr_edge", 32'(int_req), 32'h0);
    tick();
    chk_out("m1_req", 1'b1, 10'h388, 8'h02, 8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Stray int_ack in IDLE
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk_out("stray_ack", 1'b0, 10'h388, 8'h00, 8'h00);

    // No nesting: line 0 arrives while servicing line 4
    write_mask(8'hFF);
    irq = 8'h10; tick(); irq = 8'h00; tick();
    chk_out("l4_req", 1'b1, 10'h3A0, 8'h10, 8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq = 8'h01; tick(); irq = 8'h00;
    chk_out("svc_l0", 1'b0, 10'h3A0, 8'h01, 8'h10);
    tick(); tick();
    chk("svc_hold", 32'(int_req), 32'h0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk_out("l4_eoi", 1'b0, 10'h3A0, 8'h01, 8'h00);
    tick();
    chk_out("l0_req", 1'b1, 10'h380, 8'h01, 8'h00);

    // Stray eoi and a new lower-priority edge while in REQ
    eoi = 1'b1; irq = 8'h04; tick(); eoi = 1'b0; irq = 8'h00;
    chk_out("stray_eoi", 1'b1, 10'h380, 8'h05, 8'h00);
    int_ack = 1'b1; eoi = 1'b1; tick(); int_ack = 1'b0; eoi = 1'b0;
    chk_out("ack_eoi", 1'b0, 10'h380, 8'h04, 8'h01);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk_out("l2b_req", 1'b1, 10'h390, 8'h04, 8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Reset in REQ with line 6 held high
    irq = 8'h40; tick(); tick();
    chk_out("l6_req", 1'b1, 10'h3B0, 8'h40, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 10'h380, 8'h00, 8'h00);
    tick();
    reset = 1'b0;
    write_mask(8'hFF);
    tick(); tick();
    chk_out("held_high", 1'b0, 10'h380, 8'h00, 8'h00);
    irq = 8'h00; tick();
    irq = 8'h40; tick();
    chk("l6_recap", 32'(pending), 32'h40);
    tick();
    chk_out("l6_req2", 1'b1, 10'h3B0, 8'h40, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
